pipelined_alu: RTL and testbench
================================

// Module: pipelined_alu
// PURPOSE
//   Parametrised, 2-stage pipelined successor to the 4-op combinational ALU.
//   - Widens the operand width and the opcode set; opcodes 0-3 keep the legacy 4-op meaning.
//   - Adds a valid/ready handshake, result flags and a multiply-accumulate (MAC) op
//     with an internal accumulator.
//   - Sits between the config/operand issue logic and the PE output register.
// PARAMETERS
//   WIDTH    16  operand, result and accumulator width in bits (>=2)
//   OP_W      3  opcode width; only codes 0-7 are defined
// PORTS
//   CLK        in   1      clock; all state updates on the rising edge
//   RESET      in   1      synchronous, active-high reset
//   in_valid   in   1      operands/op presented
//   in_ready   out  1      pipeline can accept this cycle
//   a          in   WIDTH  operand A (unsigned)
//   b          in   WIDTH  operand B (unsigned)
//   op         in   OP_W   opcode, sampled with a/b
//   out_valid  out  1      c/zero/carry valid
//   out_ready  in   1      downstream accepts result
//   c          out  WIDTH  result
//   zero       out  1      c == 0
//   carry      out  1      ADD: carry-out; SUB: borrow (a<b); else 0
// BEHAVIOUR
//   Opcodes (all results truncated to WIDTH):
//     0 ADD  a+b
//     1 SUB  a-b
//     2 MUL  low WIDTH bits of a*b
//     3 ZERO result 0; also clears the accumulator
//     4 AND  a&b
//     5 OR   a|b
//     6 XOR  a^b
//     7 MAC  acc <= acc + low(a*b); result = new acc value
//   Handshake:
//     - Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
//     - stall = out_valid & ~out_ready; in_ready = ~stall (combinational from out_ready).
//     - No combinational path from in_valid/a/b/op to any output.
//   Pipeline:
//     - S1 registers a, b, op and v1 on every non-stall cycle (v1 = in_valid & in_ready).
//     - S2 computes from S1 and registers c, zero, carry, out_valid on every non-stall cycle.
//     - Latency: exactly 2 cycles from input transfer to out_valid, absent stalls.
//     - Throughput: 1 op/cycle.
//     - During stall, S1 and S2 hold all contents; outputs stay stable until accepted.
//     - A bubble (v1 = 0) entering S2 clears out_valid; c/zero/carry then hold their last values.
//   Accumulator (acc, WIDTH bits, internal):
//     - Updated only when a valid MAC or ZERO op loads into S2.
//     - Wraps modulo 2^WIDTH. Back-to-back MACs chain with no hazard.
//     - Other ops leave acc unchanged.
//   Reset (RESET=1 at a clock edge):
//     - v1, out_valid, c, zero, carry and acc all go to 0; zero resets to 0, not 1.
//     - Any ops in flight are discarded; in_ready is 1 the cycle after reset.
//     - in_valid is ignored while RESET=1.
//   Undefined opcodes (only possible if OP_W > 3): result 0, acc unchanged, carry 0.
// TESTING (WIDTH=16)
//   1. Legacy ops, out_ready=1: ADD 3+4; SUB 10-3; MUL 0x0100*0x0100; ZERO
//      -> c = 7, 7, 0x0000 (zero=1), 0, each exactly 2 cycles after input.
//   2. Flags: ADD 0xFFFF+1 -> c=0, zero=1, carry=1; SUB 2-5 -> c=0xFFFD, carry=1;
//      AND 0xF0F0&0x0F0F -> c=0, zero=1, carry=0.
//   3. MAC chain after ZERO: MAC(2,3), MAC(4,5), MAC(0x8000,2)
//      -> c = 6, 26, 26 (wrap); then ZERO, MAC(1,1) -> c=0, then 1.
//   4. Backpressure: stream 5 ADDs (i+i, i=1..5) with out_ready low on cycles 3-5
//      -> in_ready low exactly while stalled; outputs 2,4,6,8,10 in order, none lost or duplicated.
//   5. Reset mid-stream: assert RESET with both stages full
//      -> next cycle out_valid=0, acc=0 (next MAC(1,1) gives c=1), in_ready=1.
//   6. Random valid/ready traffic, 10k ops, vs a reference model -> bit-exact c/zero/carry sequence.

Source files
------------

// File: rtl/pipelined_alu.sv
// Two-stage pipelined ALU with valid/ready handshake, result flags and a MAC accumulator.
// S1 captures operands; S2 computes, flags and updates the accumulator. Both stages freeze together on stall.
module pipelined_alu #(
   parameter int WIDTH = 16,
   parameter int OP_W  = 3
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             zero,
   output logic             carry
);

   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_MUL  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_ZERO = OP_W'(3);
   localparam logic [OP_W-1:0] OP_AND  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_MAC  = OP_W'(7);

   logic             v1_q, v1_d;
   logic [WIDTH-1:0] a1_q, a1_d;
   logic [WIDTH-1:0] b1_q, b1_d;
   logic [OP_W-1:0]  op1_q, op1_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             stall;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] prod_lo;
   logic [WIDTH-1:0] res;
   logic             res_carry;
   logic [WIDTH-1:0] acc_nxt;

   always_comb begin
      stall     = out_valid_q & ~out_ready;
      sum       = {1'b0, a1_q} + {1'b0, b1_q};
      prod_lo   = a1_q * b1_q;
      res       = '0;
      res_carry = 1'b0;
      acc_nxt   = acc_q;

      case (op1_q)
         OP_ADD: begin
            res       = sum[WIDTH-1:0];
            res_carry = sum[WIDTH];
         end
         OP_SUB: begin
            res       = a1_q - b1_q;
            res_carry = (a1_q < b1_q);
         end
         OP_MUL:  res = prod_lo;
         OP_ZERO: begin
            res     = '0;
            acc_nxt = '0;
         end
         OP_AND:  res = a1_q & b1_q;
         OP_OR:   res = a1_q | b1_q;
         OP_XOR:  res = a1_q ^ b1_q;
         OP_MAC: begin
            acc_nxt = acc_q + prod_lo;
            res     = acc_nxt;
         end
         default: res = '0;
      endcase

      v1_d        = v1_q;
      a1_d        = a1_q;
      b1_d        = b1_q;
      op1_d       = op1_q;
      out_valid_d = out_valid_q;
      c_d         = c_q;
      zero_d      = zero_q;
      carry_d     = carry_q;
      acc_d       = acc_q;

      if (!stall) begin
         v1_d        = in_valid;
         a1_d        = a;
         b1_d        = b;
         op1_d       = op;
         out_valid_d = v1_q;
         // A bubble only drops out_valid; the data outputs keep their last values.
         if (v1_q) begin
            c_d     = res;
            zero_d  = (res == '0);
            carry_d = res_carry;
            acc_d   = acc_nxt;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         v1_q        <= 1'b0;
         a1_q        <= '0;
         b1_q        <= '0;
         op1_q       <= '0;
         out_valid_q <= 1'b0;
         c_q         <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         acc_q       <= '0;
      end else begin
         v1_q        <= v1_d;
         a1_q        <= a1_d;
         b1_q        <= b1_d;
         op1_q       <= op1_d;
         out_valid_q <= out_valid_d;
         c_q         <= c_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         acc_q       <= acc_d;
      end
   end

   assign in_ready  = ~stall;
   assign out_valid = out_valid_q;
   assign c         = c_q;
   assign zero      = zero_q;
   assign carry     = carry_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed and random scenarios for pipelined_alu at WIDTH=16, each task checking its own results.
module tb_pipelined_alu;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [2:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] c;
   logic        zero;
   logic        carry;

   int checks   = 0;
   int failures = 0;

   logic [15:0] acc_m;
   logic [17:0] exp_q[$];

   pipelined_alu #(.WIDTH(16), .OP_W(3)) dut (
      .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .c(c), .zero(zero), .carry(carry)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Reference model: returns {carry, zero, c} and advances acc_m.
   function logic [17:0] model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
      logic [16:0] s;
      logic [31:0] p;
      logic [15:0] r;
      logic        cy;
      s  = {1'b0, x} + {1'b0, y};
      p  = {16'h0, x} * {16'h0, y};
      r  = 16'h0;
      cy = 1'b0;
      case (o)
         3'd0: begin r = s[15:0]; cy = s[16]; end
         3'd1: begin r = x - y; cy = (x < y); end
         3'd2: r = p[15:0];
         3'd3: begin r = 16'h0; acc_m = 16'h0; end
         3'd4: r = x & y;
         3'd5: r = x | y;
         3'd6: r = x ^ y;
         default: begin acc_m = acc_m + p[15:0]; r = acc_m; end
      endcase
      return {cy, (r == 16'h0), r};
   endfunction

   // Issues one op alone and waits (bounded) for its result.
   task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] rc, output logic rz, output logic rcy, output int lat);
      op = o; a = x; b = y; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      rc = c; rz = zero; rcy = carry;
   endtask

   task automatic test_reset;
      RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
      tick(); tick();
      RESET = 1'b0;
      tick();
      checks++;
      if ({out_valid, in_ready, c, zero, carry} !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got ov=%b ir=%b c=%h z=%b cy=%b exp ov=0 ir=1 c=0000 z=0 cy=0",
                  out_valid, in_ready, c, zero, carry);
      end
   endtask

   task automatic test_legacy;
      logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
      logic [15:0] av  [4] = '{16'd3, 16'd10, 16'h0100, 16'd9};
      logic [15:0] bv  [4] = '{16'd4, 16'd3, 16'h0100, 16'd9};
      logic [15:0] ec  [4] = '{16'd7, 16'd7, 16'h0000, 16'h0000};
      logic        ez  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [15:0] rc;
      logic        rz, rcy;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], av[i], bv[i], rc, rz, rcy, lat);
         checks++;
         if (lat !== 2) begin
            failures++;
            $display("FAIL legacy_latency[%0d] got=%0d exp=2", i, lat);
         end
         checks++;
         if ({rc, rz} !== {ec[i], ez[i]}) begin
            failures++;
            $display("FAIL legacy_result[%0d] got c=%h z=%b exp c=%h z=%b", i, rc, rz, ec[i], ez[i]);
         end
      end
   endtask

   task automatic test_flags;
      logic [2:0]  ops [3] = '{3'd0, 3'd1, 3'd4};
      logic [15:0] av  [3] = '{16'hFFFF, 16'd2, 16'hF0F0};
      logic [15:0] bv  [3] = '{16'h0001, 16'd5, 16'h0F0F};
      logic [15:0] ec  [3] = '{16'h0000, 16'hFFFD, 16'h0000};
      logic        ez  [3] = '{1'b1, 1'b0, 1'b1};
      logic        ecy [3] = '{1'b1, 1'b1, 1'b0};
      logic [15:0] rc;
      logic        rz, rcy;
      int          lat;
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], av[i], bv[i], rc, rz, rcy, lat);
         checks++;
         if ({rc, rz, rcy} !== {ec[i], ez[i], ecy[i]}) begin
            failures++;
            $display("FAIL flags[%0d] got c=%h z=%b cy=%b exp c=%h z=%b cy=%b",
                     i, rc, rz, rcy, ec[i], ez[i], ecy[i]);
         end
      end
   endtask

   task automatic test_mac;
      logic [2:0]  ops [6] = '{3'd3, 3'd7, 3'd7, 3'd7, 3'd3, 3'd7};
      logic [15:0] av  [6] = '{16'd0, 16'd2, 16'd4, 16'h8000, 16'd0, 16'd1};
      logic [15:0] bv  [6] = '{16'd0, 16'd3, 16'd5, 16'd2, 16'd0, 16'd1};
      logic [15:0] ec  [6] = '{16'd0, 16'd6, 16'd26, 16'd26, 16'd0, 16'd1};
      logic [15:0] rc;
      logic        rz, rcy;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], av[i], bv[i], rc, rz, rcy, lat);
         checks++;
         if (rc !== ec[i]) begin
            failures++;
            $display("FAIL mac[%0d] got c=%h exp c=%h", i, rc, ec[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0]  ops [5] = '{3'd3, 3'd7, 3'd7, 3'd7, 3'd0};
      logic [15:0] av  [5] = '{16'd0, 16'd2, 16'd4, 16'h8000, 16'd1};
      logic [15:0] bv  [5] = '{16'd0, 16'd3, 16'd5, 16'd2, 16'd1};
      logic [15:0] ec  [5] = '{16'd0, 16'd6, 16'd26, 16'd26, 16'd2};
      int          got = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k < 5) begin
            in_valid = 1'b1; op = ops[k]; a = av[k]; b = bv[k];
         end else begin
            in_valid = 1'b0;
         end
         tick();
         // Results must arrive on consecutive cycles k=1..5.
         if (k >= 1 && k <= 5) begin
            checks++;
            if ({out_valid, c} !== {1'b1, ec[k-1]}) begin
               failures++;
               $display("FAIL b2b[%0d] got ov=%b c=%h exp ov=1 c=%h", k - 1, out_valid, c, ec[k-1]);
            end
         end
         if (out_valid === 1'b1) got++;
      end
      in_valid = 1'b0;
      checks++;
      if (got !== 5) begin
         failures++;
         $display("FAIL b2b_count got=%0d exp=5", got);
      end
   endtask

   task automatic test_backpressure;
      int          nxt = 1;
      int          n_out = 0;
      logic [15:0] outs [8];
      logic        exp_rdy;
      logic        acc_in;
      for (int k = 0; k < 30; k++) begin
         if (nxt <= 5) begin
            in_valid = 1'b1; op = 3'd0; a = 16'(nxt); b = 16'(nxt);
         end else begin
            in_valid = 1'b0;
         end
         out_ready = !(k >= 3 && k <= 5);
         #1;
         exp_rdy = !(k >= 3 && k <= 5);
         checks++;
         if (in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL bp_in_ready[cycle %0d] got=%b exp=%b", k, in_ready, exp_rdy);
         end
         acc_in = in_valid && in_ready;
         if (out_valid === 1'b1 && out_ready) begin
            if (n_out < 8) outs[n_out] = c;
            n_out++;
         end
         tick();
         if (acc_in) nxt++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (n_out !== 5) begin
         failures++;
         $display("FAIL bp_count got=%0d exp=5", n_out);
      end
      for (int i = 0; i < 5 && i < n_out; i++) begin
         checks++;
         if (outs[i] !== 16'(2 * (i + 1))) begin
            failures++;
            $display("FAIL bp_order[%0d] got=%h exp=%h", i, outs[i], 16'(2 * (i + 1)));
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] rc;
      logic        rz, rcy;
      int          lat;
      out_ready = 1'b1;
      in_valid = 1'b1; op = 3'd7; a = 16'd3; b = 16'd3;
      tick();
      op = 3'd0; a = 16'd1; b = 16'd2;
      tick();
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_full got ov=%b exp ov=1", out_valid);
      end
      RESET = 1'b1; op = 3'd0; a = 16'd5; b = 16'd5;
      tick();
      RESET = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, c, zero, carry} !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL rst_mid_after got ov=%b ir=%b c=%h z=%b cy=%b exp ov=0 ir=1 c=0000 z=0 cy=0",
                  out_valid, in_ready, c, zero, carry);
      end
      tick(); tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_discard got ov=%b exp ov=0", out_valid);
      end
      run_op(3'd7, 16'd1, 16'd1, rc, rz, rcy, lat);
      checks++;
      if (rc !== 16'd1) begin
         failures++;
         $display("FAIL rst_mid_acc got c=%h exp c=0001", rc);
      end
   endtask

   task automatic test_random;
      int          n_in = 0;
      int          n_out = 0;
      int          cyc = 0;
      logic        prev_stall = 1'b0;
      logic [17:0] prev_out = '0;
      logic [17:0] e;
      RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      RESET = 1'b0;
      acc_m = 16'h0;
      exp_q.delete();
      while (n_in < 10000 && cyc < 40000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         op        = 3'($urandom_range(0, 7));
         a         = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         b         = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (prev_stall) begin
            checks++;
            if ({out_valid, carry, zero, c} !== {1'b1, prev_out}) begin
               failures++;
               $display("FAIL rand_hold[cycle %0d] got ov=%b out=%h exp ov=1 out=%h",
                        cyc, out_valid, {carry, zero, c}, prev_out);
            end
         end
         if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(model(op, a, b));
            n_in++;
         end
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rand_extra[%0d] got out=%h exp none", n_out, {carry, zero, c});
            end else begin
               e = exp_q.pop_front();
               if ({carry, zero, c} !== e) begin
                  failures++;
                  $display("FAIL rand_data[%0d] got cy/z/c=%h exp=%h", n_out, {carry, zero, c}, e);
               end
            end
            n_out++;
         end
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_out   = {carry, zero, c};
         tick();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
         if (out_valid === 1'b1) begin
            checks++;
            e = exp_q.pop_front();
            if ({carry, zero, c} !== e) begin
               failures++;
               $display("FAIL rand_drain[%0d] got cy/z/c=%h exp=%h", n_out, {carry, zero, c}, e);
            end
            n_out++;
         end
         tick();
      end
      checks++;
      if (n_in !== 10000 || n_out !== n_in) begin
         failures++;
         $display("FAIL rand_totals got in=%0d out=%0d exp in=10000 out=10000", n_in, n_out);
      end
   endtask

   initial begin
      test_reset();
      test_legacy();
      test_flags();
      test_mac();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
